// File: rtl/skinny_sbox_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package  : skinny_sbox_ctrl_pkg
// Purpose  : Shared types and default constants for the byte-serial SKINNY
//            sbox8 controller and its share shifters.
// Contents : state_t FSM encoding, NBYTES_DEF, SBOX_LAT_DEF, BYTE_W.
// Options  : SKINNY_SBOX_PRECHARGE_EN adds the ST_PRECHG encoding.
// Revision : 1.0 - initial release
// ============================================================================
package skinny_sbox_ctrl_pkg;

    localparam int NBYTES_DEF   = 16;
    localparam int SBOX_LAT_DEF = 8;
    localparam int BYTE_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_HOLD   = 3'd2,
`ifdef SKINNY_SBOX_PRECHARGE_EN
        ST_PRECHG = 3'd4,
`endif
        ST_DONE   = 3'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/skinny_shared_byte_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : skinny_shared_byte_shifter
// Purpose  : Work register for one share of the masked state. Parallel load,
//            shift right by one byte with a new byte inserted at the MSB end,
//            and a tap on byte 0 (the next byte to be substituted).
// Ports    : clk, rst_n     clock / async active-low reset
//            i_load, i_din  parallel load of the whole state share
//            i_shift, i_ins shift right 8, insert i_ins at the top byte
//            o_byte0        current byte 0
//            o_q            full register contents
// Revision : 1.0 - initial release
// ============================================================================
module skinny_shared_byte_shifter
    import skinny_sbox_ctrl_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_load,
    input  logic [NBYTES*BYTE_W-1:0]   i_din,
    input  logic                       i_shift,
    input  logic [BYTE_W-1:0]          i_ins,
    output logic [BYTE_W-1:0]          o_byte0,
    output logic [NBYTES*BYTE_W-1:0]   o_q
);

    localparam int W = NBYTES * BYTE_W;

    logic [W-1:0] r_q;

    // Load wins over shift; the controller never requests both at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_din;
        end else if (i_shift) begin
            r_q <= {i_ins, r_q[W-1:BYTE_W]};
        end
    end

    assign o_byte0 = r_q[BYTE_W-1:0];
    assign o_q     = r_q;

endmodule
`default_nettype wire

// File: rtl/skinny_sbox8_hpc2_1_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : skinny_sbox8_hpc2_1_ctrl
// Purpose  : Drives one external 2-share non-pipelined HPC2 sbox8 over a
//            128-bit masked state, one byte at a time. Each byte fetches a
//            fresh 8-bit refresh mask (valid/ready), holds the sbox inputs
//            for SBOX_LAT edges, then captures the output shares.
// Ports    : clk, rst_n              clock / async active-low reset
//            start, st_in0, st_in1   start request and input state shares
//            rnd, rnd_valid,rnd_ready fresh mask handshake
//            sb_si0, sb_si1, sb_r    registered sbox inputs and mask
//            sb_bo0, sb_bo1          sbox output shares
//            st_out0, st_out1        substituted state shares
//            busy, done              status; done is a 1-cycle pulse
// Options  : SKINNY_SBOX_PRECHARGE_EN - zero the sbox inputs for one cycle
//            before every byte load (PRECHG state).
// Revision : 1.0 - initial release
// ============================================================================
module skinny_sbox8_hpc2_1_ctrl
    import skinny_sbox_ctrl_pkg::*;
#(
    parameter int NBYTES   = NBYTES_DEF,
    parameter int SBOX_LAT = SBOX_LAT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [NBYTES*BYTE_W-1:0]  st_in0,
    input  logic [NBYTES*BYTE_W-1:0]  st_in1,
    input  logic [BYTE_W-1:0]         rnd,
    input  logic                      rnd_valid,
    output logic                      rnd_ready,
    output logic [BYTE_W-1:0]         sb_si0,
    output logic [BYTE_W-1:0]         sb_si1,
    output logic [BYTE_W-1:0]         sb_r,
    input  logic [BYTE_W-1:0]         sb_bo0,
    input  logic [BYTE_W-1:0]         sb_bo1,
    output logic [NBYTES*BYTE_W-1:0]  st_out0,
    output logic [NBYTES*BYTE_W-1:0]  st_out1,
    output logic                      busy,
    output logic                      done
);

    localparam int CNT_W   = $clog2(SBOX_LAT + 1);
    localparam int IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int STATE_W = NBYTES * BYTE_W;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SBOX_LAT);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NBYTES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;

    logic               w_load;
    logic               w_shift;
    logic [BYTE_W-1:0]  w_tap0;
    logic [BYTE_W-1:0]  w_tap1;
    logic [STATE_W-1:0] w_work0;
    logic [STATE_W-1:0] w_work1;

    assign w_load  = (r_state == ST_IDLE) && start;
    // Capture edge: the SBOX_LAT-th edge after the inputs were loaded.
    assign w_shift = (r_state == ST_HOLD) && (r_cnt == c_cnt_last);

    // Each share has its own register; share-0 and share-1 data never meet.
    skinny_shared_byte_shifter #(.NBYTES(NBYTES)) u_shift0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_din   (st_in0),
        .i_shift (w_shift),
        .i_ins   (sb_bo0),
        .o_byte0 (w_tap0),
        .o_q     (w_work0)
    );

    skinny_shared_byte_shifter #(.NBYTES(NBYTES)) u_shift1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_din   (st_in1),
        .i_shift (w_shift),
        .i_ins   (sb_bo1),
        .o_byte0 (w_tap1),
        .o_q     (w_work1)
    );

    // All status outputs are registered: rnd_ready is raised on the edge
    // that enters FETCH and dropped on the edge that leaves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            sb_si0    <= '0;
            sb_si1    <= '0;
            sb_r      <= '0;
            st_out0   <= '0;
            st_out1   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rnd_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx <= '0;
                        r_cnt <= '0;
                        busy  <= 1'b1;
`ifdef SKINNY_SBOX_PRECHARGE_EN
                        sb_si0  <= '0;
                        sb_si1  <= '0;
                        sb_r    <= '0;
                        r_state <= ST_PRECHG;
`else
                        rnd_ready <= 1'b1;
                        r_state   <= ST_FETCH;
`endif
                    end
                end

`ifdef SKINNY_SBOX_PRECHARGE_EN
                ST_PRECHG: begin
                    rnd_ready <= 1'b1;
                    r_state   <= ST_FETCH;
                end
`endif

                ST_FETCH: begin
                    if (rnd_valid) begin
                        sb_si0    <= w_tap0;
                        sb_si1    <= w_tap1;
                        sb_r      <= rnd;
                        r_cnt     <= CNT_W'(1);
                        rnd_ready <= 1'b0;
                        r_state   <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_idx <= r_idx + 1'b1;
`ifdef SKINNY_SBOX_PRECHARGE_EN
                        sb_si0 <= '0;
                        sb_si1 <= '0;
                        sb_r   <= '0;
`endif
                        if (r_idx == c_idx_last) begin
                            r_state <= ST_DONE;
                        end else begin
`ifdef SKINNY_SBOX_PRECHARGE_EN
                            r_state <= ST_PRECHG;
`else
                            rnd_ready <= 1'b1;
                            r_state   <= ST_FETCH;
`endif
                        end
                    end
                end

                ST_DONE: begin
                    st_out0 <= w_work0;
                    st_out1 <= w_work1;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    rnd_ready <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_skinny_sbox8_hpc2_1_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_skinny_sbox8_hpc2_1_ctrl
// Purpose  : Scoreboard bench for skinny_sbox8_hpc2_1_ctrl. A behavioural
//            2-share sbox8 stands in for the external sbox instance.
// Options  : SKINNY_SBOX_PRECHARGE_EN selects the longer per-byte timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skinny_sbox8_hpc2_1_ctrl;
    import skinny_sbox_ctrl_pkg::*;

    localparam int NB  = NBYTES_DEF;
    localparam int LAT = SBOX_LAT_DEF;
`ifdef SKINNY_SBOX_PRECHARGE_EN
    localparam int BYTE_CYC = LAT + 2;
`else
    localparam int BYTE_CYC = LAT + 1;
`endif
    localparam int DONE_LAT = 1 + NB * BYTE_CYC;
    localparam int STALL    = 5;

    localparam logic [127:0] ALL_ONES = {128{1'b1}};
    localparam logic [127:0] S_ZERO   = {16{8'h65}};
    localparam logic [127:0] PAT_R    = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         start     = 1'b0;
    logic [127:0] st_in0    = '0;
    logic [127:0] st_in1    = '0;
    logic [7:0]   rnd       = 8'h00;
    logic         rnd_valid = 1'b0;
    logic         rnd_ready;
    logic [7:0]   sb_si0, sb_si1, sb_r, sb_bo0, sb_bo1;
    logic [127:0] st_out0, st_out1;
    logic         busy, done;

    always #5 clk = ~clk;

    skinny_sbox8_hpc2_1_ctrl #(.NBYTES(NB), .SBOX_LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .st_in0    (st_in0),
        .st_in1    (st_in1),
        .rnd       (rnd),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .sb_si0    (sb_si0),
        .sb_si1    (sb_si1),
        .sb_r      (sb_r),
        .sb_bo0    (sb_bo0),
        .sb_bo1    (sb_bo1),
        .st_out0   (st_out0),
        .st_out1   (st_out1),
        .busy      (busy),
        .done      (done)
    );

    // SKINNY-128 8-bit sbox, written from its bit-level definition.
    function automatic logic [7:0] s8(input logic [7:0] xin);
        logic [7:0] x;
        x = xin;
        for (int i = 0; i < 4; i++) begin
            x[4] = x[4] ^ ~(x[7] | x[6]);
            x[0] = x[0] ^ ~(x[3] | x[2]);
            if (i < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
            else       x = {x[7], x[6], x[5], x[4], x[3], x[1], x[2], x[0]};
        end
        return x;
    endfunction

    // Behavioural masked sbox: output re-masked with the refresh byte.
    assign sb_bo0 = s8(sb_si0 ^ sb_si1) ^ sb_r;
    assign sb_bo1 = sb_r;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int hs_cnt = 0;
    always @(posedge clk) if (rst_n && rnd_ready && rnd_valid) hs_cnt <= hs_cnt + 1;

    int n_pass  = 0;
    int n_total = 0;
    int n_done  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        int           done_cyc;
        logic [127:0] xor_exp;
        bit           masked;
        string        name;
    } exp_t;

    exp_t sb_q[$];

    // Monitor: every done pulse pops one expected result.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_done_cycle"}, cyc, e.done_cyc);
                    check({e.name, "_unmasked"}, st_out0 ^ st_out1, e.xor_exp);
                    if (e.masked) check({e.name, "_share0_masked"}, st_out0 != e.xor_exp, 1);
                    n_done++;
                end
            end
        end
    end

    // Hold checker: after every rnd handshake the sbox inputs must stay
    // frozen and rnd_ready low for the whole latency window.
    initial begin : hold_chk
        logic [23:0] snap, seen;
        logic [7:0]  rnd_hs;
        logic        rr;
        bit          aborted;
        forever begin
            @(posedge clk);
            if (rst_n && rnd_ready && rnd_valid) begin
                rnd_hs = rnd;
                @(negedge clk);
                snap    = {sb_si0, sb_si1, sb_r};
                seen    = snap;
                rr      = rnd_ready;
                aborted = 1'b0;
                check("load_sb_r", sb_r, rnd_hs);
                for (int k = 1; k < LAT; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if ({sb_si0, sb_si1, sb_r} != snap) seen = {sb_si0, sb_si1, sb_r};
                    rr = rr | rnd_ready;
                end
                if (!aborted) begin
                    check("hold_sb_stable", seen, snap);
                    check("hold_rnd_ready_low", rr, 0);
                end
            end
        end
    end

    // Randomness source; can stall once before a chosen handshake.
    int stall_hs = -1;
    initial begin : rnd_drv
        int served;
        served = -1;
        forever begin
            @(negedge clk);
            rnd       = 8'($urandom_range(1, 255));
            rnd_valid = 1'b1;
            if (stall_hs >= 0 && stall_hs != served && rnd_ready && hs_cnt == stall_hs) begin
                served    = stall_hs;
                rnd_valid = 1'b0;
                for (int k = 0; k < STALL; k++) begin
                    @(negedge clk);
                    check("t3_stall_rnd_ready", rnd_ready, 1);
                end
                rnd_valid = 1'b1;
            end
        end
    end

    task automatic issue(input logic [127:0] a0, input logic [127:0] a1, input string name,
                         input logic [127:0] xexp, input bit masked, input int extra,
                         input bit push, output int s_edge);
        exp_t e;
        @(negedge clk);
        st_in0 = a0;
        st_in1 = a1;
        start  = 1'b1;
        s_edge = cyc + 1;
        if (push) begin
            e.done_cyc = s_edge + DONE_LAT + extra;
            e.xor_exp  = xexp;
            e.masked   = masked;
            e.name     = name;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start  = 1'b0;
        st_in0 = ~a0;
        st_in1 = a1 ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        check({name, "_busy"}, busy, 1);
    endtask

    task automatic wait_done(input int target, input string name);
        int k;
        k = 0;
        while (n_done < target && k < DONE_LAT + 40) begin
            @(negedge clk);
            k++;
        end
        check({name, "_completed"}, n_done, target);
    endtask

    initial begin : stim
        int s;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rnd_ready", rnd_ready, 0);
        check("rst_sb", {sb_si0, sb_si1, sb_r}, 0);
        check("rst_st_out", {st_out0, st_out1}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_rnd_ready", rnd_ready, 0);

        // Zero state, rnd always valid.
        issue('0, '0, "t1", S_ZERO, 1'b0, 0, 1'b1, s);
        wait_done(1, "t1");

        // All-ones in share 0: S(0xFF)=0xFF, shares randomised by rnd.
        issue(ALL_ONES, '0, "t2", ALL_ONES, 1'b1, 0, 1'b1, s);
        wait_done(2, "t2");

        // Randomness stall in front of byte 3.
        stall_hs = hs_cnt + 3;
        issue('0, '0, "t3", S_ZERO, 1'b0, STALL, 1'b1, s);
        wait_done(3, "t3");
        stall_hs = -1;

        // Second start in the middle of an operation must be ignored.
        issue(ALL_ONES, '0, "t5", ALL_ONES, 1'b1, 0, 1'b1, s);
        while (cyc < s + 39) @(negedge clk);
        st_in0 = '0;
        st_in1 = PAT_R;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done(4, "t5");

        // Reset in the middle of an operation.
        issue({8{16'h00ff}}, '0, "t6a", '0, 1'b0, 0, 1'b0, s);
        while (cyc < s + 59) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_rnd_ready", rnd_ready, 0);
        check("t6_rst_sb", {sb_si0, sb_si1, sb_r}, 0);
        check("t6_rst_st_out", {st_out0, st_out1}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (DONE_LAT) @(negedge clk);
        check("t6_after_rst_busy", busy, 0);
        issue(PAT_R, PAT_R, "t6b", S_ZERO, 1'b1, 0, 1'b1, s);
        wait_done(5, "t6b");

        repeat (20) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
